// File: rtl/flag_gen_serial.sv
// Serial A - B subtractor computing A + ~B + 1 one SLICE-bit slice per cycle.
// Publishes the difference and NZCV flags through a valid/ready handshake.
module flag_gen_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] D,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One slice of the ripple adder; bit SLICE is the carry-out.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             zacc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic [WIDTH-1:0] d_r;
  logic             busy_r, valid_r, z_r, n_r, c_r, v_r;

  int               base_s;
  logic [SLICE-1:0] a_slice_s;
  logic [SLICE-1:0] nb_slice_s;
  logic [SLICE:0]   sum_s;
  logic             msb_cin_s;
  logic             slice_zero_s;
  logic             last_s;

  // Current slice arithmetic; MSB carry-in is recovered from the sum bit.
  always_comb begin
    base_s       = int'(cnt_r) * SLICE;
    a_slice_s    = a_r[base_s +: SLICE];
    nb_slice_s   = nb_r[base_s +: SLICE];
    sum_s        = slice_add(a_slice_s, nb_slice_s, carry_r);
    msb_cin_s    = sum_s[SLICE-1] ^ a_slice_s[SLICE-1] ^ nb_slice_s[SLICE-1];
    slice_zero_s = (sum_s[SLICE-1:0] == {SLICE{1'b0}});
    last_s       = (cnt_r == CW'(NS - 1));
  end

  // Control FSM, slice datapath and registered result/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b1;
      zacc_r  <= 1'b1;
      a_r     <= {WIDTH{1'b0}};
      nb_r    <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      z_r     <= 1'b0;
      n_r     <= 1'b0;
      c_r     <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            nb_r    <= ~B;
            carry_r <= 1'b1;
            zacc_r  <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SUB;
          end else begin
            state_r <= IDLE;
          end
        end
        SUB: begin
          d_r[base_s +: SLICE] <= sum_s[SLICE-1:0];
          carry_r <= sum_s[SLICE];
          zacc_r  <= zacc_r & slice_zero_s;
          if (last_s) begin
            c_r     <= sum_s[SLICE];
            v_r     <= msb_cin_s ^ sum_s[SLICE];
            n_r     <= sum_s[SLICE-1];
            z_r     <= zacc_r & slice_zero_s;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          // A start while stalled is ignored; it only counts alongside ready.
          if (ready) begin
            valid_r <= 1'b0;
            if (start) begin
              a_r     <= A;
              nb_r    <= ~B;
              carry_r <= 1'b1;
              zacc_r  <= 1'b1;
              cnt_r   <= {CW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= SUB;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign valid = valid_r;
  assign D     = d_r;
  assign Z     = z_r;
  assign N     = n_r;
  assign C     = c_r;
  assign V     = v_r;

endmodule
